// File: rtl/tile_address_sequencer_if.sv
// Address stream bundle between the match controller (master) and the
// tile address sequencer (slave) feeding the SRAM read port.
interface tile_address_sequencer_if #(
  parameter int ADDR_W = 21
) ();
  logic              start;
  logic [7:0]        set;
  logic              frame;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              addr_last;
  logic              region;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, set, frame, mode, addr_ready,
    input  addr, addr_valid, addr_last, region, busy, done, err
  );

  modport slave (
    input  start, set, frame, mode, addr_ready,
    output addr, addr_valid, addr_last, region, busy, done, err
  );
endinterface

// File: rtl/tile_address_sequencer.sv
// Streams SRAM word addresses for one template and/or search-window tile.
// state | meaning: IDLE wait start | TEM template beats | WIN window beats | DONE done pulse
module tile_address_sequencer #(
  parameter int ADDR_W      = 21,
  parameter int TEM_W       = 8,
  parameter int TEM_H       = 8,
  parameter int WIN_W       = 20,
  parameter int WIN_H       = 80,
  parameter int WIN_OFFSET  = 65,
  parameter int SET_WORDS   = 1665,
  parameter int NUM_SETS    = 150,
  parameter int FRAME1_BASE = 249750
) (
  input  logic                     clk,
  input  logic                     rst,
  tile_address_sequencer_if.slave  s
);
  typedef enum logic [1:0] {S_IDLE, S_TEM, S_WIN, S_DONE} state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] TEM_COL_LAST = CNT_W'(TEM_W - 1);
  localparam logic [CNT_W-1:0] TEM_ROW_LAST = CNT_W'(TEM_H - 1);
  localparam logic [CNT_W-1:0] WIN_COL_LAST = CNT_W'(WIN_W - 1);
  localparam logic [CNT_W-1:0] WIN_ROW_LAST = CNT_W'(WIN_H - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic              mode2_q, mode2_d;
  logic              valid_q, valid_d, last_q, last_d, region_q, region_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic              xfer, load, col_end, row_end, final_region;
  logic [CNT_W-1:0]  col_last, row_last;
  logic [ADDR_W-1:0] start_base, row_term;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    mode2_d    = mode2_q;
    valid_d    = valid_q;
    last_d     = last_q;
    region_d   = region_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;
    xfer       = valid_q && s.addr_ready;
    start_base = (s.frame ? ADDR_W'(FRAME1_BASE) : '0)
                 + ADDR_W'(32'(s.set) * 32'(SET_WORDS));
    col_last   = (state_q == S_WIN) ? WIN_COL_LAST : TEM_COL_LAST;
    row_last   = (state_q == S_WIN) ? WIN_ROW_LAST : TEM_ROW_LAST;
    col_end    = (col_q == col_last);
    row_end    = (row_q == row_last);
    // only the last region of the sequence may carry addr_last
    final_region = (state_q == S_WIN) || !mode2_q;

    case (state_q)
      S_IDLE: begin
        if (s.start) begin
          if ((32'(s.set) >= 32'(NUM_SETS)) || (s.mode == 2'd3)) begin
            err_d = 1'b1;
          end else begin
            base_d   = start_base;
            mode2_d  = (s.mode == 2'd2);
            region_d = (s.mode == 2'd1);
            state_d  = (s.mode == 2'd1) ? S_WIN : S_TEM;
            row_d    = '0;
            col_d    = '0;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            last_d   = (s.mode == 2'd1) ? (WIN_W * WIN_H == 1)
                     : ((s.mode == 2'd0) && (TEM_W * TEM_H == 1));
            load     = 1'b1;
          end
        end
      end
      S_TEM, S_WIN: begin
        if (xfer) begin
          if (col_end && row_end) begin
            if ((state_q == S_TEM) && mode2_q) begin
              state_d  = S_WIN;
              region_d = 1'b1;
              row_d    = '0;
              col_d    = '0;
              last_d   = (WIN_W * WIN_H == 1);
              load     = 1'b1;
            end else begin
              state_d  = S_DONE;
              valid_d  = 1'b0;
              last_d   = 1'b0;
              region_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end
          end else begin
            if (col_end) begin
              col_d = '0;
              row_d = row_q + ONE;
            end else begin
              col_d = col_q + ONE;
            end
            last_d = final_region && (row_d == row_last) && (col_d == col_last);
            load   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    row_term = region_d ? ADDR_W'(WIN_OFFSET) + ADDR_W'(32'(row_d) * 32'(WIN_W))
                        : ADDR_W'(32'(row_d) * 32'(TEM_W));
    addr_d   = load ? (base_d + row_term + ADDR_W'(col_d)) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      mode2_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      region_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      mode2_q  <= mode2_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      region_q <= region_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign s.addr       = addr_q;
  assign s.addr_valid = valid_q;
  assign s.addr_last  = last_q;
  assign s.region     = region_q;
  assign s.busy       = busy_q;
  assign s.done       = done_q;
  assign s.err        = err_q;
endmodule

// File: tb/tb_tile_address_sequencer.sv
// Scoreboard bench for tile_address_sequencer: expected beats come from a
// flat per-region address walk and are checked by an independent monitor.
module tb_tile_address_sequencer;
  localparam int ADDR_W     = 21;
  localparam int STALL_ADDR = 1670;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_address_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  tile_address_sequencer #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .s(bus));

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              region;
  } beat_t;

  beat_t exp_q[$];
  int    tests     = 0;
  int    fails     = 0;
  int    rdy_mode  = 0;
  int    stall_cnt = 0;
  logic  done_exp  = 1'b0;
  logic  in_seq    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: each region is a contiguous run of words from its base.
  task automatic push_model(input logic f, input int st, input int md);
    int unsigned base;
    beat_t b;
    base = (f ? 249750 : 0) + st * 1665;
    if (md == 0 || md == 2)
      for (int i = 0; i < 64; i++) begin
        b.addr = ADDR_W'(base + i); b.region = 1'b0; b.last = (md == 0 && i == 63);
        exp_q.push_back(b);
      end
    if (md == 1 || md == 2)
      for (int i = 0; i < 1600; i++) begin
        b.addr = ADDR_W'(base + 65 + i); b.region = 1'b1; b.last = (i == 1599);
        exp_q.push_back(b);
      end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      if (!bus.busy && !bus.done && exp_q.size() == 0) return;
    end
    tests++; fails++;
    $display("FAIL %s: timeout waiting for idle, %0d beats still expected", nm, exp_q.size());
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic f, input int st, input int md);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.frame = f; bus.set = 8'(st); bus.mode = 2'(md);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_seq(input string nm, input logic f, input int st, input int md);
    wait_idle({nm, "_pre"});
    push_model(f, st, md);
    pulse_start(f, st, md);
    wait_idle(nm);
  endtask

  task automatic do_reject(input string nm, input logic f, input int st, input int md);
    wait_idle({nm, "_pre"});
    pulse_start(f, st, md);
    @(negedge clk);
    chk({nm, "_err"}, 32'(bus.err), 32'd1);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_valid"}, 32'(bus.addr_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_err_clr"}, 32'(bus.err), 32'd0);
    chk({nm, "_busy2"}, 32'(bus.busy), 32'd0);
    chk({nm, "_valid2"}, 32'(bus.addr_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_addr"}, 32'(bus.addr), 32'd0);
    chk({nm, "_valid"}, 32'(bus.addr_valid), 32'd0);
    chk({nm, "_last"}, 32'(bus.addr_last), 32'd0);
    chk({nm, "_region"}, 32'(bus.region), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin : ready_driver
    bus.addr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.addr_ready = 1'b1;
        1: bus.addr_ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (bus.addr_valid && 32'(bus.addr) == STALL_ADDR && stall_cnt < 5) begin
            bus.addr_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.addr_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin : monitor
    beat_t e;
    logic  done_nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_exp = 1'b0;
        in_seq   = 1'b0;
        continue;
      end
      done_nxt = 1'b0;
      chk("done_pulse", 32'(bus.done), 32'(done_exp));
      if (done_exp) begin
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        chk("valid_in_done", 32'(bus.addr_valid), 32'd0);
      end
      if (in_seq) begin
        chk("no_bubble_valid", 32'(bus.addr_valid), 32'd1);
        chk("busy_in_seq", 32'(bus.busy), 32'd1);
      end
      if (bus.addr_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got addr %0d, expected no beat at %0t", bus.addr, $time);
        end else begin
          in_seq = 1'b1;
          e = exp_q[0];
          chk("addr", 32'(bus.addr), 32'(e.addr));
          chk("addr_last", 32'(bus.addr_last), 32'(e.last));
          chk("region", 32'(bus.region), 32'(e.region));
          if (bus.addr_ready) begin
            void'(exp_q.pop_front());
            if (e.last) begin
              done_nxt = 1'b1;
              in_seq   = 1'b0;
            end
          end
        end
      end
      done_exp = done_nxt;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d beats still expected", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int st, md;
    logic f;
    bus.start = 1'b0; bus.set = '0; bus.frame = 1'b0; bus.mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    rdy_mode = 0;
    run_seq("tem_walk", 1'b0, 0, 0);
    run_seq("win_set149", 1'b1, 149, 1);
    run_seq("combined", 1'b0, 2, 2);

    rdy_mode = 2; stall_cnt = 0;
    run_seq("backpressure", 1'b0, 1, 0);
    chk("stall_cycles", 32'(stall_cnt), 32'd5);
    rdy_mode = 0;

    do_reject("rej_set150", 1'b0, 150, 0);
    do_reject("rej_mode3", 1'b1, 5, 3);

    wait_idle("busy_start_pre");
    push_model(1'b0, 3, 0);
    pulse_start(1'b0, 3, 0);
    repeat (10) @(posedge clk);
    pulse_start(1'b1, 7, 1);
    @(negedge clk);
    chk("busy_start_no_err", 32'(bus.err), 32'd0);
    wait_idle("busy_start");

    wait_idle("rst_mid_pre");
    push_model(1'b0, 0, 1);
    pulse_start(1'b0, 0, 1);
    begin : find_beat
      for (int i = 0; i < 200; i++) begin
        if (bus.addr_valid && 32'(bus.addr) == 32'd85) disable find_beat;
        @(posedge clk); #1;
      end
      tests++; fails++;
      $display("FAIL rst_mid_find: got no beat at addr 85, expected one");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_all_zero("rst_mid");
    run_seq("after_rst", 1'b0, 4, 0);

    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      f  = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 159);
      md = $urandom_range(0, 3);
      if (st >= 150 || md == 3) do_reject("rand_rej", f, st, md);
      else run_seq("rand_seq", f, st, md);
    end
    rdy_mode = 0;
    wait_idle("final");
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
